// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered RV32I/RV64I decode stage between fetch and register-read.
//   The instruction is decoded combinationally on entry and captured in a
//   main output register; a second (skid) register absorbs one extra entry so
//   in_ready can be a flop yet throughput stays at one instruction per cycle.
//   Order is strictly FIFO. flush drops both held entries.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             synchronous kill of all held entries (wins over all)
//   in_valid/in_ready upstream handshake; in_ready is registered (!skid_full)
//   in_instr, in_pc   fetched instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_opcode..out_func7  raw instruction fields
//   out_imm           sign-extended immediate for the decoded format
//   out_fmt           R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   out_illegal       instruction not decodable (still delivered)
//   out_pc            PC carried through
module instr_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{instr: '0, imm: '0, fmt: FMT_NONE,
                                   illegal: 1'b0, pc: '0};

  function automatic logic [2:0] decode_fmt(input logic [6:0] op);
    case (op)
      7'b0110011:                       decode_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:           decode_fmt = FMT_I;
      7'b0100011:                       decode_fmt = FMT_S;
      7'b1100011:                       decode_fmt = FMT_B;
      7'b0110111, 7'b0010111:           decode_fmt = FMT_U;
      7'b1101111:                       decode_fmt = FMT_J;
      default:                          decode_fmt = FMT_NONE;
    endcase
  endfunction

  // All immediates are formed as 32-bit signed values, then widened so
  // bit 31 is replicated up to XLEN.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] w,
                                                 input logic [2:0]  fmt);
    logic signed [31:0] imm32;
    case (fmt)
      FMT_I:   imm32 = {{20{w[31]}}, w[31:20]};
      FMT_S:   imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   imm32 = {w[31:12], 12'b0};
      FMT_J:   imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    decode_imm = XLEN'(imm32);
  endfunction

  function automatic logic decode_illegal(input logic [31:0] w,
                                          input logic [2:0]  fmt);
    logic ill;
    ill = (w[1:0] != 2'b11) || (fmt == FMT_NONE);
    if (fmt == FMT_R) begin
      case (w[31:25])
        7'b0000000: ;
        7'b0100000: if (!(w[14:12] == 3'b000 || w[14:12] == 3'b101)) ill = 1'b1;
        7'b0000001: if (!ENABLE_M) ill = 1'b1;
        default:    ill = 1'b1;
      endcase
    end
    decode_illegal = ill;
  endfunction

  // ---- stage p0: combinational decode of the incoming word ----
  entry_t dec_p0;

  always_comb begin
    dec_p0.instr   = in_instr;
    dec_p0.fmt     = decode_fmt(in_instr[6:0]);
    dec_p0.imm     = decode_imm(in_instr, dec_p0.fmt);
    dec_p0.illegal = decode_illegal(in_instr, dec_p0.fmt);
    dec_p0.pc      = in_pc;
  end

  // ---- stage p1: main output register plus skid register ----
  entry_t main_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   rdy_q;
  logic   vld_nxt;
  logic   skid_vld_nxt;
  logic   load_main_skid;
  logic   load_main_in;
  logic   load_skid;
  logic   in_xfer;
  logic   main_free;

  assign in_xfer   = in_valid & rdy_q;
  // Main can take a new entry if it is empty or being drained this cycle.
  assign main_free = ~vld_p1 | out_ready;

  always_comb begin
    vld_nxt        = vld_p1;
    skid_vld_nxt   = skid_vld_p1;
    load_main_skid = 1'b0;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        // Older skid entry moves up first; a new input refills the skid.
        load_main_skid = 1'b1;
        vld_nxt        = 1'b1;
        load_skid      = in_xfer;
        skid_vld_nxt   = in_xfer;
      end else begin
        load_main_in = in_xfer;
        vld_nxt      = in_xfer;
      end
    end else if (in_xfer) begin
      load_skid    = 1'b1;
      skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      vld_p1      <= vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      rdy_q       <= ~skid_vld_nxt;
    end
  end

  // Main data is reset so the outputs read as zero / NONE out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1 <= ENTRY_RST;
    end else if (load_main_skid) begin
      main_p1 <= skid_p1;
    end else if (load_main_in) begin
      main_p1 <= dec_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_p1 <= dec_p0;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_p1;
  assign out_opcode  = main_p1.instr[6:0];
  assign out_rd      = main_p1.instr[11:7];
  assign out_func3   = main_p1.instr[14:12];
  assign out_rs1     = main_p1.instr[19:15];
  assign out_rs2     = main_p1.instr[24:20];
  assign out_func7   = main_p1.instr[31:25];
  assign out_imm     = main_p1.imm;
  assign out_fmt     = main_p1.fmt;
  assign out_illegal = main_p1.illegal;
  assign out_pc      = main_p1.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: two instances (XLEN=32/ENABLE_M=0 and
// XLEN=64/ENABLE_M=1) share one stimulus stream. A capacity-2 FIFO model
// and an arithmetic decode model predict every output each cycle.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [6:0]  out_opcode_a, out_func7_a;
  logic [4:0]  out_rd_a, out_rs1_a, out_rs2_a;
  logic [2:0]  out_func3_a, out_fmt_a;
  logic [31:0] out_imm_a, out_pc_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [6:0]  out_opcode_b, out_func7_b;
  logic [4:0]  out_rd_b, out_rs1_b, out_rs2_b;
  logic [2:0]  out_func3_b, out_fmt_b;
  logic [63:0] out_imm_b, out_pc_b;

  instr_decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_opcode(out_opcode_a), .out_rd(out_rd_a), .out_func3(out_func3_a),
    .out_rs1(out_rs1_a), .out_rs2(out_rs2_a), .out_func7(out_func7_a),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .out_pc(out_pc_a)
  );

  instr_decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_opcode(out_opcode_b), .out_rd(out_rd_b), .out_func3(out_func3_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_func7(out_func7_b),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .out_pc(out_pc_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    bit          illegal;
  } ref_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    bit          ill_a, ill_b;
  } vec_t;
  vec_t vec[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] w, input bit en_m);
    ref_t r;
    longint u;
    int op, f3, f7;
    u  = longint'(w);
    op = int'(u & 127);
    f3 = int'((u >> 12) & 7);
    f7 = int'((u >> 25) & 127);
    r.imm = 0;
    case (op)
      'h33: r.fmt = 3'd0;
      'h13, 'h03, 'h67, 'h73, 'h0F: r.fmt = 3'd1;
      'h23: r.fmt = 3'd2;
      'h63: r.fmt = 3'd3;
      'h37, 'h17: r.fmt = 3'd4;
      'h6F: r.fmt = 3'd5;
      default: r.fmt = 3'd7;
    endcase
    case (r.fmt)
      3'd1: r.imm = sext(u >> 20, 12);
      3'd2: r.imm = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd3: r.imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                         (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd4: r.imm = sext(u & 64'hFFFFF000, 32);
      3'd5: r.imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                         (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      default: r.imm = 0;
    endcase
    r.illegal = ((u & 3) != 3) || (r.fmt == 3'd7);
    if (r.fmt == 3'd0 && !((f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) ||
                           (f7 == 1 && en_m)))
      r.illegal = 1'b1;
    return r;
  endfunction

  task automatic check_outputs();
    ent_t e;
    ref_t ra, rb;
    chk("out_valid_a", out_valid_a, q.size() > 0);
    chk("out_valid_b", out_valid_b, q.size() > 0);
    chk("in_ready_a", in_ready_a, q.size() < 2);
    chk("in_ready_b", in_ready_b, q.size() < 2);
    if (q.size() > 0) begin
      e  = q[0];
      ra = ref_decode(e.instr, 1'b0);
      rb = ref_decode(e.instr, 1'b1);
      chk("fields_a", {out_func7_a, out_rs2_a, out_rs1_a, out_func3_a, out_rd_a, out_opcode_a}, e.instr);
      chk("fields_b", {out_func7_b, out_rs2_b, out_rs1_b, out_func3_b, out_rd_b, out_opcode_b}, e.instr);
      chk("imm_a", out_imm_a, ra.imm[31:0]);
      chk("imm_b", out_imm_b, rb.imm);
      chk("fmt_a", out_fmt_a, ra.fmt);
      chk("fmt_b", out_fmt_b, rb.fmt);
      chk("illegal_a", out_illegal_a, ra.illegal);
      chk("illegal_b", out_illegal_b, rb.illegal);
      chk("pc_a", out_pc_a, e.pc[31:0]);
      chk("pc_b", out_pc_b, e.pc);
    end
  endtask

  // Check current outputs, advance the FIFO model by the coming edge, step.
  task automatic cycle();
    ent_t e;
    int   n;
    check_outputs();
    n = q.size();
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && n > 0) q.delete(0);
      if (in_valid && n < 2) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {out_valid_a, out_valid_b}, 2'b00);
    chk({tag, "_in_ready"}, {in_ready_a, in_ready_b}, 2'b11);
    chk({tag, "_fmt"}, {out_fmt_a, out_fmt_b}, 6'o77);
    chk({tag, "_imm_a"}, out_imm_a, 0);
    chk({tag, "_imm_b"}, out_imm_b, 0);
    chk({tag, "_pc_b"}, out_pc_b, 0);
    chk({tag, "_fields_a"}, {out_func7_a, out_rs2_a, out_rs1_a, out_func3_a, out_rd_a, out_opcode_a, out_illegal_a}, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 13))
      0:  w[6:0] = 7'h33;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h03;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h73;
      5:  w[6:0] = 7'h0F;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h63;
      8:  w[6:0] = 7'h37;
      9:  w[6:0] = 7'h17;
      10: w[6:0] = 7'h6F;
      11: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      12: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int emerged;
    vec[0] = '{32'hFFF10093, 3'd1, 5'd1, 5'd2, 5'd31, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vec[1] = '{32'h00512423, 3'd2, 5'd8, 5'd2, 5'd5, 64'h8, 1'b0, 1'b0};
    vec[2] = '{32'hFE000EE3, 3'd3, 5'd29, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vec[3] = '{32'h123450B7, 3'd4, 5'd1, 5'd8, 5'd3, 64'h12345000, 1'b0, 1'b0};
    vec[4] = '{32'h022081B3, 3'd0, 5'd3, 5'd1, 5'd2, 64'h0, 1'b1, 1'b0};
    vec[5] = '{32'h00000000, 3'd7, 5'd0, 5'd0, 5'd0, 64'h0, 1'b1, 1'b1};
    vec[6] = '{32'hFFFFFFFF, 3'd7, 5'd31, 5'd31, 5'd31, 64'h0, 1'b1, 1'b1};
    vec[7] = '{32'h40000033, 3'd0, 5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b0};
    vec[8] = '{32'h40001033, 3'd0, 5'd0, 5'd0, 5'd0, 64'h0, 1'b1, 1'b1};
    vec[9] = '{32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd8, 64'h8, 1'b0, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table stream, one per cycle, latency 1
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = vec[i].instr;
      in_pc    = {$urandom(), $urandom()};
      cycle();
      chk("tbl_valid", out_valid_a, 1'b1);
      chk("tbl_fmt_a", out_fmt_a, vec[i].fmt);
      chk("tbl_fmt_b", out_fmt_b, vec[i].fmt);
      chk("tbl_rd", out_rd_a, vec[i].rd);
      chk("tbl_rs1", out_rs1_a, vec[i].rs1);
      chk("tbl_rs2", out_rs2_b, vec[i].rs2);
      chk("tbl_imm_a", out_imm_a, vec[i].imm[31:0]);
      chk("tbl_imm_b", out_imm_b, vec[i].imm);
      chk("tbl_ill_a", out_illegal_a, vec[i].ill_a);
      chk("tbl_ill_b", out_illegal_b, vec[i].ill_b);
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: upstream holds each word until accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_instr = vec[k].instr;
      in_pc    = 64'h1000 + 64'(4 * k);
      if (in_ready_a) begin
        cycle();
        k++;
      end else begin
        cycle();
      end
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", in_ready_a, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    emerged = 0;
    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      if (out_valid_a) emerged++;
      cycle();
    end
    chk("bp_emerged", emerged, 2);
    chk("bp_drained", q.size(), 0);

    // Flush with both entries full and a new input presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = vec[5].instr;
    cycle();
    in_instr  = vec[6].instr;
    cycle();
    flush    = 1'b1;
    in_instr = vec[7].instr;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", {out_valid_a, out_valid_b}, 2'b00);
    chk("flush_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("flush_no_output", out_valid_a, 1'b0);
      cycle();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom(), $urandom()};
      cycle();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4 && q.size() > 0; c++) cycle();
    chk("rand_drained", q.size(), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = vec[0].instr;
    cycle();
    in_instr  = vec[3].instr;
    cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
